// File: rtl/ttt_turn_sequencer_if.sv
// Request, strobe and status bundle between the requesters, the game and ttt_turn_sequencer.
// timeout_flag exists only when TTT_TURN_TIMEOUT_EN is defined.
interface ttt_turn_sequencer_if;
    logic       player_req;
    logic [3:0] player_pos;
    logic       comp_req;
    logic [3:0] comp_pos;
    logic [1:0] who;
    logic       play;
    logic       pc;
    logic [3:0] player_position;
    logic [3:0] computer_position;
    logic       turn;
    logic       busy;
    logic       illegal;
    logic       out_of_turn;
    logic [8:0] occupied;
    logic [3:0] move_count;
    logic       game_over;
    logic [1:0] result;
`ifdef TTT_TURN_TIMEOUT_EN
    logic       timeout_flag;

    modport master (
        output player_req, player_pos, comp_req, comp_pos, who,
        input  play, pc, player_position, computer_position, turn, busy, illegal,
               out_of_turn, occupied, move_count, game_over, result, timeout_flag
    );
    modport slave (
        input  player_req, player_pos, comp_req, comp_pos, who,
        output play, pc, player_position, computer_position, turn, busy, illegal,
               out_of_turn, occupied, move_count, game_over, result, timeout_flag
    );
`else
    modport master (
        output player_req, player_pos, comp_req, comp_pos, who,
        input  play, pc, player_position, computer_position, turn, busy, illegal,
               out_of_turn, occupied, move_count, game_over, result
    );
    modport slave (
        input  player_req, player_pos, comp_req, comp_pos, who,
        output play, pc, player_position, computer_position, turn, busy, illegal,
               out_of_turn, occupied, move_count, game_over, result
    );
`endif
endinterface

// File: rtl/ttt_turn_sequencer.sv
// Turn sequencer for tic_tac_toe_game: alternates player/computer moves and issues play/pc strobes.
// Optional player-turn forfeit timeout enabled by defining TTT_TURN_TIMEOUT_EN.
module ttt_turn_sequencer #(
    parameter int unsigned SETTLE_CYCLES  = 2,
    parameter int unsigned FIRST_MOVER    = 0,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input logic                 clock,
    input logic                 reset,
    ttt_turn_sequencer_if.slave bus
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
        $error("SETTLE_CYCLES must be in 1..15");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    typedef enum logic [2:0] {
        StPWait, StPIssue, StPSettle, StCWait, StCIssue, StCSettle, StDone
    } state_e;

    localparam state_e StReset = (FIRST_MOVER != 0) ? StCWait : StPWait;

    state_e     state_q, state_d;
    logic       play_q, play_d, pc_q, pc_d;
    logic [3:0] ppos_q, ppos_d, cpos_q, cpos_d;
    logic       turn_q, turn_d, busy_q, busy_d;
    logic       illegal_q, illegal_d, oot_q, oot_d;
    logic [8:0] occ_q, occ_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] res_q, res_d;
    logic       over_q, over_d;
    logic [3:0] settle_q, settle_d;

    // Shifting past bit 8 yields an empty mask, so out-of-range indices never alias a cell.
    logic [8:0] p_mask, c_mask;
    logic       p_legal, c_legal, any_req;

    assign p_mask  = 9'd1 << bus.player_pos;
    assign c_mask  = 9'd1 << bus.comp_pos;
    assign p_legal = (bus.player_pos <= 4'd8) && ((p_mask & occ_q) == 9'd0);
    assign c_legal = (bus.comp_pos <= 4'd8) && ((c_mask & occ_q) == 9'd0);
    assign any_req = bus.player_req | bus.comp_req;

`ifdef TTT_TURN_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          tflag_q, tflag_d;
`endif

    always_comb begin
        state_d   = state_q;
        play_d    = 1'b0;
        pc_d      = 1'b0;
        illegal_d = 1'b0;
        oot_d     = 1'b0;
        ppos_d    = ppos_q;
        cpos_d    = cpos_q;
        turn_d    = turn_q;
        busy_d    = busy_q;
        occ_d     = occ_q;
        cnt_d     = cnt_q;
        res_d     = res_q;
        over_d    = over_q;
        settle_d  = settle_q;
`ifdef TTT_TURN_TIMEOUT_EN
        tcnt_d    = tcnt_q;
        tflag_d   = 1'b0;
`endif
        unique case (state_q)
            StPWait: begin
                oot_d = bus.comp_req;
                if (bus.player_req && p_legal) begin
                    ppos_d  = bus.player_pos;
                    occ_d   = occ_q | p_mask;
                    cnt_d   = cnt_q + 4'd1;
                    play_d  = 1'b1;
                    busy_d  = 1'b1;
                    state_d = StPIssue;
                end else begin
                    illegal_d = bus.player_req;
`ifdef TTT_TURN_TIMEOUT_EN
                    if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        tflag_d = 1'b1;
                        turn_d  = 1'b1;
                        state_d = StCWait;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
`endif
                end
            end
            StCWait: begin
                oot_d = bus.player_req;
                if (bus.comp_req && c_legal) begin
                    cpos_d  = bus.comp_pos;
                    occ_d   = occ_q | c_mask;
                    cnt_d   = cnt_q + 4'd1;
                    pc_d    = 1'b1;
                    busy_d  = 1'b1;
                    state_d = StCIssue;
                end else begin
                    illegal_d = bus.comp_req;
                end
            end
            StPIssue, StCIssue: begin
                oot_d    = any_req;
                settle_d = 4'(SETTLE_CYCLES);
                state_d  = (state_q == StPIssue) ? StPSettle : StCSettle;
            end
            StPSettle, StCSettle: begin
                oot_d    = any_req;
                settle_d = settle_q - 4'd1;
                if (settle_q == 4'd1) begin
                    busy_d = 1'b0;
                    if (bus.who == 2'b01 || bus.who == 2'b10 || cnt_q == 4'd9) begin
                        res_d   = (bus.who == 2'b01 || bus.who == 2'b10) ? bus.who : 2'b11;
                        over_d  = 1'b1;
                        state_d = StDone;
                    end else if (state_q == StPSettle) begin
                        turn_d  = 1'b1;
                        state_d = StCWait;
                    end else begin
                        turn_d  = 1'b0;
                        state_d = StPWait;
`ifdef TTT_TURN_TIMEOUT_EN
                        tcnt_d  = '0;
`endif
                    end
                end
            end
            StDone: ;
            default: state_d = StReset;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= StReset;
            play_q    <= 1'b0;
            pc_q      <= 1'b0;
            illegal_q <= 1'b0;
            oot_q     <= 1'b0;
            ppos_q    <= 4'd0;
            cpos_q    <= 4'd0;
            turn_q    <= (FIRST_MOVER != 0);
            busy_q    <= 1'b0;
            occ_q     <= 9'd0;
            cnt_q     <= 4'd0;
            res_q     <= 2'b00;
            over_q    <= 1'b0;
            settle_q  <= 4'd0;
`ifdef TTT_TURN_TIMEOUT_EN
            tcnt_q    <= '0;
            tflag_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            play_q    <= play_d;
            pc_q      <= pc_d;
            illegal_q <= illegal_d;
            oot_q     <= oot_d;
            ppos_q    <= ppos_d;
            cpos_q    <= cpos_d;
            turn_q    <= turn_d;
            busy_q    <= busy_d;
            occ_q     <= occ_d;
            cnt_q     <= cnt_d;
            res_q     <= res_d;
            over_q    <= over_d;
            settle_q  <= settle_d;
`ifdef TTT_TURN_TIMEOUT_EN
            tcnt_q    <= tcnt_d;
            tflag_q   <= tflag_d;
`endif
        end
    end

    assign bus.play              = play_q;
    assign bus.pc                = pc_q;
    assign bus.player_position   = ppos_q;
    assign bus.computer_position = cpos_q;
    assign bus.turn              = turn_q;
    assign bus.busy              = busy_q;
    assign bus.illegal           = illegal_q;
    assign bus.out_of_turn       = oot_q;
    assign bus.occupied          = occ_q;
    assign bus.move_count        = cnt_q;
    assign bus.game_over         = over_q;
    assign bus.result            = res_q;
`ifdef TTT_TURN_TIMEOUT_EN
    assign bus.timeout_flag      = tflag_q;
`endif

endmodule

// File: tb/tb_ttt_turn_sequencer.sv
// Randomised and directed bench for ttt_turn_sequencer against a move-level reference model.
// Define TTT_TURN_TIMEOUT_EN to build and check the timeout variant (TIMEOUT_CYCLES = 20).
module tb_ttt_turn_sequencer;

    localparam int S = 2;
`ifdef TTT_TURN_TIMEOUT_EN
    localparam int T = 20;
`else
    localparam int T = 1000;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ttt_turn_sequencer_if bus ();

    ttt_turn_sequencer #(
        .SETTLE_CYCLES (S),
        .FIRST_MOVER   (0),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clock(clk),
        .reset(rst_n),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Reference model: whose turn, whether a move is in flight and how old it is, board contents.
    bit         m_turn, m_active, m_mover, m_done;
    int         m_age, m_cnt, m_idle;
    logic [8:0] m_occ;
    logic [1:0] m_res;
    logic [3:0] m_ppos, m_cpos;
    bit         e_play, e_pc, e_ill, e_oot, e_tf;

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit rst, input bit preq, input logic [3:0] ppos,
                              input bit creq, input logic [3:0] cpos, input logic [1:0] w);
        bit req, other, legal;
        int p;
        e_play = 0; e_pc = 0; e_ill = 0; e_oot = 0; e_tf = 0;
        if (!rst) begin
            m_turn = 0; m_active = 0; m_done = 0; m_occ = '0; m_cnt = 0;
            m_res = 2'b00; m_ppos = 0; m_cpos = 0; m_idle = 0; m_age = 0;
        end else if (m_done) begin
            // game finished: everything ignored
        end else if (m_active) begin
            m_age++;
            e_oot = preq | creq;
            if (m_age == S + 1) begin
                m_active = 0;
                if (w == 2'b01 || w == 2'b10) begin
                    m_res = w; m_done = 1;
                end else if (m_cnt == 9) begin
                    m_res = 2'b11; m_done = 1;
                end else begin
                    m_turn = !m_mover;
                    m_idle = 0;
                end
            end
        end else begin
            req   = m_turn ? creq : preq;
            other = m_turn ? preq : creq;
            p     = m_turn ? int'(cpos) : int'(ppos);
            e_oot = other;
            legal = (p < 9) ? !m_occ[p] : 1'b0;
            if (req && legal) begin
                m_occ[p] = 1'b1;
                m_cnt++;
                if (m_turn) m_cpos = 4'(p); else m_ppos = 4'(p);
                m_active = 1; m_age = 0; m_mover = m_turn;
                e_play = !m_turn; e_pc = m_turn;
            end else begin
                e_ill = req;
`ifdef TTT_TURN_TIMEOUT_EN
                if (!m_turn) begin
                    if (m_idle == T - 1) begin
                        m_turn = 1; e_tf = 1;
                    end else begin
                        m_idle++;
                    end
                end
`endif
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("play", 9'(bus.play), 9'(e_play));
            check("pc", 9'(bus.pc), 9'(e_pc));
            check("illegal", 9'(bus.illegal), 9'(e_ill));
            check("out_of_turn", 9'(bus.out_of_turn), 9'(e_oot));
            check("busy", 9'(bus.busy), 9'(m_active));
            check("turn", 9'(bus.turn), 9'(m_turn));
            check("occupied", bus.occupied, m_occ);
            check("move_count", 9'(bus.move_count), 9'(m_cnt));
            check("game_over", 9'(bus.game_over), 9'(m_done));
            check("result", 9'(bus.result), 9'(m_res));
            check("player_position", 9'(bus.player_position), 9'(m_ppos));
            check("computer_position", 9'(bus.computer_position), 9'(m_cpos));
`ifdef TTT_TURN_TIMEOUT_EN
            check("timeout_flag", 9'(bus.timeout_flag), 9'(e_tf));
`endif
        end
    end

    // Called at a negedge; applies inputs for one clock edge and returns at the next negedge.
    task automatic step(input bit rst, input bit preq, input logic [3:0] ppos,
                        input bit creq, input logic [3:0] cpos, input logic [1:0] w);
        rst_n = rst;
        bus.player_req = preq; bus.player_pos = ppos;
        bus.comp_req = creq;   bus.comp_pos = cpos;
        bus.who = w;
        @(posedge clk);
        model_step(rst, preq, ppos, creq, cpos, w);
        @(negedge clk);
        chk_en = 1'b1;
    endtask

    task automatic idle(input int n, input logic [1:0] w);
        for (int i = 0; i < n; i++) step(1, 0, 4'd0, 0, 4'd0, w);
    endtask

    task automatic move(input bit comp, input logic [3:0] pos, input logic [1:0] w);
        step(1, !comp, pos, comp, pos, 2'b00);
        idle(S + 1, w);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(0, i[0], 4'(i), !i[0], 4'(i), 2'b00);
        step(1, 0, 4'd0, 0, 4'd0, 2'b00);
    endtask

    function automatic logic [3:0] pick_pos();
        int free[$];
        for (int i = 0; i < 9; i++) if (!m_occ[i]) free.push_back(i);
        if (free.size() != 0 && $urandom_range(0, 3) != 0)
            return 4'(free[$urandom_range(0, free.size() - 1)]);
        return 4'($urandom_range(0, 15));
    endfunction

    initial begin
        int done_cyc;
        bus.player_req = 0; bus.player_pos = 0; bus.comp_req = 0; bus.comp_pos = 0;
        bus.who = 2'b00;
        @(negedge clk);

        // Reset with requests toggling, then release
        do_reset(10);
        check("t1_turn", 9'(bus.turn), 9'd0);
        check("t1_occ", bus.occupied, 9'd0);

        // Player cell 0, computer cell 2
        step(1, 1, 4'd0, 0, 4'd0, 2'b00);
        check("t2_play", 9'(bus.play), 9'd1);
        idle(S + 1, 2'b00);
        check("t2_turn", 9'(bus.turn), 9'd1);
        step(1, 0, 4'd0, 1, 4'd2, 2'b00);
        check("t2_pc", 9'(bus.pc), 9'd1);
        check("t2_cpos", 9'(bus.computer_position), 9'd2);
        idle(S + 1, 2'b00);
        check("t2_model_occ", m_occ, 9'b000000101);
        check("t2_occ", bus.occupied, 9'b000000101);
        check("t2_cnt", 9'(bus.move_count), 9'd2);

        // Illegal index and occupied cell
        step(1, 1, 4'd9, 0, 4'd0, 2'b00);
        check("t3_ill_idx", 9'(bus.illegal), 9'd1);
        step(1, 1, 4'd0, 0, 4'd0, 2'b00);
        check("t3_ill_occ", 9'(bus.illegal), 9'd1);
        check("t3_cnt", 9'(bus.move_count), 9'd2);

        // Out-of-turn requests
        step(1, 0, 4'd0, 1, 4'd5, 2'b00);
        check("t4_oot_wait", 9'(bus.out_of_turn), 9'd1);
        step(1, 1, 4'd4, 0, 4'd0, 2'b00);
        idle(1, 2'b00);
        step(1, 1, 4'd6, 0, 4'd0, 2'b00);
        check("t4_oot_settle", 9'(bus.out_of_turn), 9'd1);
        idle(1, 2'b00);
        check("t4_occ", bus.occupied, 9'b000010101);

        // Player wins with 0,1,2
        do_reset(2);
        move(0, 4'd0, 2'b00); move(1, 4'd3, 2'b00);
        move(0, 4'd1, 2'b00); move(1, 4'd4, 2'b00);
        move(0, 4'd2, 2'b01);
        check("t5_model_res", 9'(m_res), 9'd1);
        check("t5_res", 9'(bus.result), 9'd1);
        check("t5_over", 9'(bus.game_over), 9'd1);
        step(1, 1, 4'd5, 1, 4'd6, 2'b00);
        check("t5_oot", 9'(bus.out_of_turn), 9'd0);
        step(1, 1, 4'd7, 1, 4'd8, 2'b10);
        check("t5_res_hold", 9'(bus.result), 9'd1);

        // Nine-move draw
        do_reset(2);
        move(0, 4'd0, 2'b00); move(1, 4'd1, 2'b00); move(0, 4'd2, 2'b00);
        move(1, 4'd4, 2'b00); move(0, 4'd3, 2'b00); move(1, 4'd5, 2'b00);
        move(0, 4'd7, 2'b00); move(1, 4'd6, 2'b00); move(0, 4'd8, 2'b00);
        check("t5_model_draw", 9'(m_res), 9'd3);
        check("t5_draw", 9'(bus.result), 9'd3);
        check("t5_full", bus.occupied, 9'h1ff);

        // Reset while play is high
        do_reset(2);
        step(1, 1, 4'd4, 0, 4'd0, 2'b00);
        step(0, 0, 4'd0, 0, 4'd0, 2'b00);
        check("t6_play", 9'(bus.play), 9'd0);
        check("t6_cnt", 9'(bus.move_count), 9'd0);
        check("t6_ppos", 9'(bus.player_position), 9'd0);

`ifdef TTT_TURN_TIMEOUT_EN
        step(1, 0, 4'd0, 0, 4'd0, 2'b00);
        idle(T - 2, 2'b00);
        check("t6_turn_pre", 9'(bus.turn), 9'd0);
        idle(1, 2'b00);
        check("t6_tflag", 9'(bus.timeout_flag), 9'd1);
        check("t6_turn_post", 9'(bus.turn), 9'd1);
`endif

        // Randomised play
        done_cyc = 0;
        for (int c = 0; c < 4000; c++) begin
            bit rst, own, oth;
            logic [1:0] w;
            logic [3:0] pos, opos;
            rst  = !(done_cyc >= 4 || $urandom_range(0, 199) == 0);
            own  = ($urandom_range(0, 2) == 0);
            oth  = ($urandom_range(0, 7) == 0);
            pos  = pick_pos();
            opos = pick_pos();
            w    = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            if (m_turn) step(rst, oth, opos, own, pos, w);
            else        step(rst, own, pos, oth, opos, w);
            done_cyc = m_done ? done_cyc + 1 : 0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
